// File: rtl/branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue
//
// In-order tracking queue that sits directly downstream of a 2-bit saturating
// branch predictor. Fetch branch requests are gated into the predictor, each
// returned prediction is captured into a small FIFO, and when execute resolves
// the oldest in-flight branch the stored prediction is compared against the
// actual outcome. The predictor's update strobe (result/taken) and a
// mispredict pulse are driven one cycle after each accepted resolve.
//
// Optional feature macro: BRQ_STATS_EN
//   When defined, adds saturating statistics counters resolved_cnt and
//   mispred_cnt (CNT_W bits each). When undefined, those ports are absent.
//
// Parameters
//   DEPTH  in-flight branch entries (power of two, >= 2)
//   CNT_W  statistics counter width (only used with BRQ_STATS_EN)
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   issue          fetch presents a branch needing a prediction
//   request        to predictor, issue & ~full (combinational)
//   prediction     from predictor, valid the cycle after request
//   resolve_valid  execute resolves the oldest in-flight branch
//   resolve_taken  actual direction, qualified by resolve_valid
//   result         to predictor, one-cycle update strobe
//   taken          to predictor, actual direction qualified by result
//   mispredict     pulses with result when stored prediction != actual
//   full / empty   occupancy flags (post-edge state)
//   count          entries reserved
//   underflow      sticky, set by a resolve while empty
//   resolved_cnt   (BRQ_STATS_EN) accepted resolves, saturating
//   mispred_cnt    (BRQ_STATS_EN) mispredicts, saturating
// -----------------------------------------------------------------------------
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue,
  output logic                     request,
  input  logic                     prediction,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     result,
  output logic                     taken,
  output logic                     mispredict,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     underflow
`ifdef BRQ_STATS_EN
  ,
  output logic [CNT_W-1:0]         resolved_cnt,
  output logic [CNT_W-1:0]         mispred_cnt
`endif
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

  // Elaboration-time parameter sanity hooks; both bodies are intentionally
  // empty, the conditions only document the legal parameter space.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_not_pow2
  end
  if (CNT_W < 1) begin : g_cnt_w_too_small
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic            pred_mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q,  wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q,  rd_ptr_d;
  logic [AW:0]     count_q,   count_d;
  logic            cap_pend_q, cap_pend_d;
  logic [AW-1:0]   cap_idx_q,  cap_idx_d;
  logic            result_q,   result_d;
  logic            taken_q,    taken_d;
  logic            mispred_q,  mispred_d;
  logic            underflow_q, underflow_d;

  logic            full_w;
  logic            empty_w;
  logic            do_pop;
  logic            pred_cmp;
  logic            mis_now;

  // ---------------------------------------------------------------------------
  // Combinational datapath / next state
  // ---------------------------------------------------------------------------
  // Flags come straight from the registered count, so they reflect the
  // pre-edge occupancy: a resolve in the same cycle cannot open a slot for an
  // issue while full.
  assign full_w  = (count_q == FULL_CNT);
  assign empty_w = (count_q == '0);

  assign request = issue & ~full_w;
  assign do_pop  = resolve_valid & ~empty_w;

  // The entry being resolved may still be waiting for its prediction to land
  // in storage (issued last cycle); in that case compare the live input.
  always_comb begin
    pred_cmp = pred_mem_q[rd_ptr_q];
    if (cap_pend_q && (cap_idx_q == rd_ptr_q)) begin
      pred_cmp = prediction;
    end
  end

  assign mis_now = do_pop & (pred_cmp != resolve_taken);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    cap_pend_d  = request;
    cap_idx_d   = cap_idx_q;
    result_d    = do_pop;
    taken_d     = do_pop & resolve_taken;
    mispred_d   = mis_now;
    underflow_d = underflow_q | (resolve_valid & empty_w);

    if (request) begin
      wr_ptr_d  = wr_ptr_q + PTR_ONE;
      cap_idx_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    unique case ({request, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cap_pend_q  <= 1'b0;
      cap_idx_q   <= '0;
      result_q    <= 1'b0;
      taken_q     <= 1'b0;
      mispred_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cap_pend_q  <= cap_pend_d;
      cap_idx_q   <= cap_idx_d;
      result_q    <= result_d;
      taken_q     <= taken_d;
      mispred_q   <= mispred_d;
      underflow_q <= underflow_d;
    end
  end

  // Prediction storage has no reset; a discarded pending capture is simply
  // suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && cap_pend_q) begin
      pred_mem_q[cap_idx_q] <= prediction;
    end
  end

  assign result     = result_q;
  assign taken      = taken_q;
  assign mispredict = mispred_q;
  assign full       = full_w;
  assign empty      = empty_w;
  assign count      = count_q;
  assign underflow  = underflow_q;

`ifdef BRQ_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics counters
  // ---------------------------------------------------------------------------
  localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] resolved_cnt_q, resolved_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q,  mispred_cnt_d;

  always_comb begin
    resolved_cnt_d = resolved_cnt_q;
    mispred_cnt_d  = mispred_cnt_q;
    if (do_pop && (resolved_cnt_q != '1)) begin
      resolved_cnt_d = resolved_cnt_q + STAT_ONE;
    end
    if (mis_now && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + STAT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resolved_cnt_q <= '0;
      mispred_cnt_q  <= '0;
    end else begin
      resolved_cnt_q <= resolved_cnt_d;
      mispred_cnt_q  <= mispred_cnt_d;
    end
  end

  assign resolved_cnt = resolved_cnt_q;
  assign mispred_cnt  = mispred_cnt_q;
`endif

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

In-order tracking queue placed directly downstream of the 2-bit saturating branch predictor. It gates fetch branch requests into the predictor and captures each returned prediction into a FIFO. When branches resolve, it compares the actual outcome with the oldest stored prediction, flags mispredicts, and drives the predictor's `result`/`taken` update inputs.

## Interface
- `DEPTH`, 4: in-flight branch entries; power of two, ≥2.
- `CNT_W`, 16: width of statistics counters; only used with `BRQ_STATS_EN`.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `issue`  in  1  fetch presents a branch needing a prediction.
- `request`  out  1  to predictor; `issue & ~full` (combinational).
- `prediction`  in  1  from predictor; valid the cycle after `request`.
- `resolve_valid`  in  1  execute resolves the oldest in-flight branch.
- `resolve_taken`  in  1  actual direction; qualified by `resolve_valid`.
- `result`  out  1  to predictor; one-cycle update strobe.
- `taken`  out  1  to predictor; actual direction, qualified by `result`.
- `mispredict`  out  1  pulse with `result` when the stored prediction ≠ actual.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  $clog2(DEPTH)+1  entries reserved.
- `underflow`  out  1  sticky; set when `resolve_valid` arrives while empty.

## Operation
- Storage: DEPTH×1-bit prediction array, write/read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, and an occupancy `count`.
- Issue: an accepted request (`request`=1) reserves the slot at `wr_ptr` and increments the pointer and count at that edge. It also sets `cap_pend` with `cap_idx`=old `wr_ptr`.
- Capture: in the cycle with `cap_pend`=1, `prediction` is written into slot `cap_idx`. `cap_pend` then clears unless a new request was accepted in the same cycle.
- An `issue` seen while full is not accepted; `request`=0 and fetch holds.
- Resolve: `resolve_valid` with count>0 pops slot `rd_ptr`, advances `rd_ptr`, and decrements count. The compared prediction is the stored bit. If `cap_pend`=1 and `cap_idx`==`rd_ptr`, the compared prediction bypasses from the live `prediction` input instead.
- Resolve while empty: no pop, no strobe, `underflow`←1. Only reset clears it.
- Simultaneous accepted issue and resolve: count is unchanged and both pointers advance. While full, a resolve in the same cycle does not enable the issue, because `full` is evaluated on the pre-edge count.
- A resolve in the same cycle as the request that reserves its entry is impossible, because count was 0. That case is treated as underflow.

## Timing
- `request`: combinational, zero latency from `issue`.
- `result`, `taken`, `mispredict`: registered, asserted exactly one cycle after the accepted `resolve_valid`, one cycle wide. Back-to-back resolves produce back-to-back strobes.
- `full`, `empty`, `count`: registered and reflect post-edge state.
- Reset (`rst_n`=0 at a rising edge): pointers=0, count=0, `cap_pend`=0, `result`=`taken`=`mispredict`=0, `underflow`=0, `empty`=1, `full`=0. Storage contents are don't-care.
- Reset mid-operation discards all in-flight entries and any pending capture. No strobe is issued for discarded entries.

## Configuration
- `BRQ_STATS_EN` defined: adds outputs `resolved_cnt` and `mispred_cnt` (each CNT_W bits). They increment on each accepted resolve and each mispredict respectively, saturate at all-ones, and are cleared by reset.
- Undefined: these ports and counters are absent and all other behaviour is identical.

## Test plan
- Reset, then idle: `empty`=1, `count`=0, `request`=`result`=`mispredict`=0, `underflow`=0.
- Issue 4 branches on consecutive cycles (DEPTH=4) with predictions 1,1,0,1, then a 5th issue: `full`=1 and `request`=0 for the 5th. Resolve taken 1,0,0,0: `mispredict` pulses on the 2nd and 4th strobes, `taken`=1,0,0,0, ending `empty`=1.
- Issue at cycle N and resolve at N+1 with prediction=1 and actual=0 (bypass path): `result`=1, `taken`=0, `mispredict`=1 at N+2.
- With count=2, issue and resolve in the same cycle for 10 cycles: `count` stays 2, pointers wrap twice, and every strobe compares the correct entry.
- Resolve while empty: no `result` pulse and `underflow` stays 1 until `rst_n`=0.
- With `BRQ_STATS_EN`, CNT_W=2: 5 resolves containing 4 mispredicts give `resolved_cnt`=3 and `mispred_cnt`=3 (saturated). Asserting reset with 3 entries in flight gives count=0 and no strobes afterwards.
